// File: rtl/fetch_pc_queue_if.sv
// Fetch-stage bus bundle: redirect, branch-buffer lookup, instruction memory and decode handshake.
// The master side is the fetch queue itself; the slave side is its surrounding environment.
interface fetch_pc_queue_if;
    logic        flush;
    logic [31:0] flush_pc;
    logic        btb_hit;
    logic [31:0] btb_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_pred_taken;
    logic [31:0] out_pred_target;

    modport master (
        input  flush, flush_pc, btb_hit, btb_target, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_inst, out_pred_taken, out_pred_target
    );

    modport slave (
        output flush, flush_pc, btb_hit, btb_target, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_inst, out_pred_taken, out_pred_target
    );
endinterface

// File: rtl/fetch_pc_queue.sv
// Fetch PC generator with branch-buffer redirect, a single outstanding memory read
// and a 2-entry instruction queue with registered head outputs.
module fetch_pc_queue #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_queue_if.master bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
    } entry_t;

    logic [31:0] pc_q;

    logic        infl_vld_p1;
    logic [31:0] infl_pc_p1;
    logic        infl_pt_p1;
    logic [31:0] infl_tgt_p1;

    entry_t      mem_q [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        head_vld_p2;
    entry_t      head_p2;

    logic        pop;
    logic        pop_eff;
    logic        push;
    logic        pred;
    logic [2:0]  occ;
    logic        rd_ptr_n;
    logic [1:0]  count_n;
    entry_t      push_ent;
    entry_t      head_n;

    // Occupancy counts the in-flight read so a returning word always has a slot.
    assign pop           = head_vld_p2 && bus.out_ready;
    assign occ           = {1'b0, count} + {2'b00, infl_vld_p1} - {2'b00, pop};
    assign bus.imem_req  = !rst && !bus.flush && (occ < 3'd2);
    assign bus.imem_addr = pc_q;
    assign pred          = bus.imem_req && bus.btb_hit && (bus.btb_target[1:0] == 2'b00);
    assign push          = infl_vld_p1 && !bus.flush;
    assign pop_eff       = pop && !bus.flush;
    assign push_ent      = {infl_pc_p1, bus.imem_rdata, infl_pt_p1, infl_tgt_p1};

    always_comb begin
        rd_ptr_n = rd_ptr ^ pop_eff;
        count_n  = count + {1'b0, push} - {1'b0, pop_eff};
        // The slot being written becomes the head only when nothing older survives.
        if (push && (wr_ptr == rd_ptr_n)) begin
            head_n = push_ent;
        end else begin
            head_n = mem_q[rd_ptr_n];
        end
    end

    // Control state: PC, in-flight valid, queue pointers and head valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            infl_vld_p1 <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            head_vld_p2 <= 1'b0;
        end else if (bus.flush) begin
            pc_q        <= bus.flush_pc & ~32'h3;
            infl_vld_p1 <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            head_vld_p2 <= 1'b0;
        end else begin
            if (pred) begin
                pc_q <= bus.btb_target;
            end else if (bus.imem_req) begin
                pc_q <= pc_q + 32'd4;
            end
            infl_vld_p1 <= bus.imem_req;
            rd_ptr      <= rd_ptr_n;
            wr_ptr      <= wr_ptr ^ push;
            count       <= count_n;
            head_vld_p2 <= (count_n != 2'd0);
        end
    end

    // Datapath: in-flight record, queue storage and head copy.
    always_ff @(posedge clk) begin
        if (bus.imem_req) begin
            infl_pc_p1  <= pc_q;
            infl_pt_p1  <= pred;
            infl_tgt_p1 <= pred ? bus.btb_target : 32'h0;
        end
        if (push) begin
            mem_q[wr_ptr] <= push_ent;
        end
        head_p2 <= head_n;
    end

    assign bus.out_valid       = head_vld_p2 && !rst;
    assign bus.out_pc          = rst ? 32'h0 : head_p2.pc;
    assign bus.out_inst        = rst ? 32'h0 : head_p2.inst;
    assign bus.out_pred_taken  = rst ? 1'b0  : head_p2.pred_taken;
    assign bus.out_pred_target = rst ? 32'h0 : head_p2.pred_target;

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Bench for fetch_pc_queue: directed scenarios followed by random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_fetch_pc_queue;

    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam logic [31:0] MEM_KEY  = 32'hA5A5A5A5;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_pc_queue_if bus ();

    fetch_pc_queue #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t        q[$];
    logic [31:0] mpc  = RESET_PC;
    logic        mf_v = 1'b0;
    ent_t        mf;
    logic [31:0] btb_tab [logic [31:0]];
    logic [31:0] rd_addr = 32'h0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, answer the branch-buffer lookup, check, advance the model.
    task automatic cyc(input logic r, input logic f, input logic [31:0] fpc, input logic rdy);
        logic [31:0] a;
        logic [31:0] tgt;
        logic [31:0] addr_seen;
        logic        hit;
        logic        pop;
        logic        ereq;
        logic        epred;
        logic        req_seen;
        int          occ;
        rst           = r;
        bus.flush     = f;
        bus.flush_pc  = fpc;
        bus.out_ready = rdy;
        bus.imem_rdata = rd_addr ^ MEM_KEY;
        #1;
        a = bus.imem_addr;
        if (btb_tab.exists(a)) begin
            bus.btb_hit    = 1'b1;
            bus.btb_target = btb_tab[a];
        end else begin
            bus.btb_hit    = 1'b0;
            bus.btb_target = $urandom;
        end
        #1;
        hit   = btb_tab.exists(mpc);
        tgt   = hit ? btb_tab[mpc] : 32'h0;
        pop   = (q.size() > 0) && rdy && !r;
        occ   = q.size() + (mf_v ? 1 : 0) - (pop ? 1 : 0);
        ereq  = !r && !f && (occ < 2);
        epred = ereq && hit && (tgt[1:0] == 2'b00);

        chk("imem_req", {31'b0, bus.imem_req}, {31'b0, ereq});
        if (!r) chk("imem_addr", bus.imem_addr, mpc);
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, (!r && q.size() > 0)});
        if (r) begin
            chk("rst_out_pc", bus.out_pc, 32'h0);
            chk("rst_out_inst", bus.out_inst, 32'h0);
            chk("rst_out_pt", {31'b0, bus.out_pred_taken}, 32'h0);
            chk("rst_out_tgt", bus.out_pred_target, 32'h0);
        end else if (q.size() > 0) begin
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("out_inst", bus.out_inst, q[0].pc ^ MEM_KEY);
            chk("out_pred_taken", {31'b0, bus.out_pred_taken}, {31'b0, q[0].pt});
            chk("out_pred_target", bus.out_pred_target, q[0].tgt);
        end
        req_seen  = bus.imem_req;
        addr_seen = bus.imem_addr;

        @(posedge clk);
        if (r) begin
            q.delete();
            mf_v = 1'b0;
            mpc  = RESET_PC;
        end else if (f) begin
            q.delete();
            mf_v = 1'b0;
            mpc  = {fpc[31:2], 2'b00};
        end else begin
            if (pop) void'(q.pop_front());
            if (mf_v) q.push_back(mf);
            mf_v = ereq;
            if (ereq) mf = '{mpc, epred, (epred ? tgt : 32'h0)};
            if (epred) mpc = tgt;
            else if (ereq) mpc = mpc + 32'd4;
        end
        if (req_seen) rd_addr = addr_seen;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.flush      = 1'b0;
        bus.flush_pc   = 32'h0;
        bus.out_ready  = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.btb_hit    = 1'b0;
        bus.btb_target = 32'h0;
        btb_tab[32'h00000008] = 32'h00000100;
        btb_tab[32'h00000040] = 32'h00000102;
        @(posedge clk);
        #1;

        // Reset, then sequential fetch with the predicted jump at 8 -> 0x100.
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (10) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // Backpressure for 5 cycles, then drain.
        repeat (5) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // Flush with a full queue (pop in the flush cycle ignored).
        repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h00000203, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // Flush with a request in flight, then back-to-back flushes.
        cyc(1'b0, 1'b1, 32'h00000300, 1'b1);
        cyc(1'b0, 1'b1, 32'h00000404, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // Misaligned prediction at 0x40 is ignored.
        cyc(1'b0, 1'b1, 32'h00000040, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // PC wrap, fill the queue, then reset mid-operation.
        cyc(1'b0, 1'b1, 32'hFFFFFFF8, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic with a populated branch buffer.
        for (int k = 0; k < 16; k++) begin
            logic [31:0] key;
            key = 32'($urandom_range(0, 255)) << 2;
            btb_tab[key] = 32'($urandom_range(0, 1023));
        end
        for (int i = 0; i < 400; i++) begin
            logic        rr;
            logic        ff;
            logic        rdy;
            logic [31:0] fpc;
            rr  = ($urandom_range(0, 99) == 0);
            ff  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            fpc = 32'($urandom_range(0, 1023));
            cyc(rr, ff, fpc, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pc_queue.md
FETCH_PC_QUEUE -- requirements
Module: fetch_pc_queue

Interface
REQ-001 The block SHALL have one parameter, RESET_PC, default 32'h00000000: the fetch address after reset.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  redirect request from the branch buffer or execute stage.
REQ-006 flush_pc  input  32  redirect target.
REQ-007 btb_hit  input  1  predicted-taken for the address on imem_addr, valid in the same cycle.
REQ-008 btb_target  input  32  predicted target for the address on imem_addr.
REQ-009 imem_req  output  1  instruction-memory read request.
REQ-010 imem_addr  output  32  fetch address; also drives the branch-buffer lookup.
REQ-011 imem_rdata  input  32  instruction word, valid in the cycle after the accepted request.
REQ-012 out_valid  output  1  queue head holds a valid instruction.
REQ-013 out_ready  input  1  decode accepts the head.
REQ-014 out_pc  output  32  PC of the head entry.
REQ-015 out_inst  output  32  instruction word of the head entry.
REQ-016 out_pred_taken  output  1  prediction applied when the head entry was fetched.
REQ-017 out_pred_target  output  32  predicted target of the head entry (0 when not taken).

Function
REQ-018 The block SHALL hold a PC register pc_q, a one-deep in-flight record {valid, pc, pred_taken, pred_target}, and a 2-entry FIFO of {pc, inst, pred_taken, pred_target}.
REQ-019 imem_addr SHALL equal pc_q combinationally.
REQ-020 pop SHALL be out_valid && out_ready.
REQ-021 imem_req SHALL be 1 iff !rst && !flush && (count + inflight_valid - pop) < 2.
- This gives one fetch per cycle in steady state; the FIFO never overflows.
REQ-022 Prediction SHALL be used (pred = 1) iff imem_req && btb_hit && btb_target[1:0] == 2'b00; a misaligned target SHALL be treated as not-taken.
REQ-023 Next pc_q SHALL follow this priority, first match wins:
- rst -> RESET_PC
- flush -> {flush_pc[31:2], 2'b00}
- pred -> btb_target
- imem_req -> pc_q + 4, wrapping modulo 2^32
- otherwise -> hold
REQ-024 On an issue edge, the in-flight record SHALL capture {1, pc_q, pred, pred ? btb_target : 0}; otherwise its valid bit SHALL clear.
REQ-025 When the in-flight record is valid and flush is 0, the FIFO SHALL push {pc, imem_rdata, pred_taken, pred_target} at that edge.
REQ-026 Push and pop in the same cycle SHALL both take effect; count is unchanged.
REQ-027 Push into an empty FIFO SHALL make out_valid rise in the next cycle; the FIFO SHALL have no combinational bypass.
REQ-028 Latency from request to out_valid SHALL be 2 cycles.
REQ-029 Head outputs SHALL be registered.
REQ-030 Head outputs SHALL hold stable while out_valid && !out_ready.
REQ-031 flush SHALL take priority over everything except rst. At the flush edge the block SHALL:
- empty the FIFO;
- clear the in-flight record, discarding its returning imem_rdata;
- load pc_q.
REQ-032 In the cycle after a flush, imem_req SHALL be 1 with imem_addr equal to the redirect address.
REQ-033 Back-to-back flushes SHALL each redirect; the last one wins.
REQ-034 A pop in the same cycle as a flush SHALL be ignored; decode squashes its own copy.
REQ-035 count SHALL be 0..2; wrap-around of the 1-bit read and write pointers SHALL be internal only.

Reset
REQ-036 While rst is 1, the block SHALL drive imem_req=0, out_valid=0, out_pc=0, out_inst=0, out_pred_taken=0, out_pred_target=0.
REQ-037 At the reset edge, the FIFO SHALL empty, the in-flight record SHALL clear, and pc_q SHALL be set to RESET_PC.
REQ-038 Reset asserted mid-operation SHALL discard all queued and in-flight instructions.
REQ-039 The first cycle with rst=0 SHALL issue a request to RESET_PC.

Verification
REQ-040 Reset, then out_ready=1, no hits; memory returns addr^32'hA5A5A5A5 -> imem_addr 0,4,8,... on consecutive cycles; out_valid rises 2 cycles after the first request; out_pc 0,4,8 with matching out_inst; one instruction per cycle.
REQ-041 Predicted jump: btb_hit=1 with btb_target=32'h100 while imem_addr=32'h8 -> next imem_addr=32'h100; entry 8 is delivered with out_pred_taken=1 and out_pred_target=32'h100; the following entry has out_pc=32'h100.
REQ-042 Backpressure: out_ready=0 for 5 cycles -> exactly 2 entries are queued; imem_req=0 while full; head is stable; on release entries drain in order with no loss or duplication.
REQ-043 Flush with a full FIFO and a request in flight, flush_pc=32'h203 -> next cycle out_valid=0; imem_req=1 with imem_addr=32'h200; no stale entry ever appears.
REQ-044 Misaligned prediction: btb_hit=1 with btb_target=32'h102 at imem_addr=32'h40 -> next imem_addr=32'h44; out_pred_taken=0.
REQ-045 Wrap and reset: pc_q=32'hFFFFFFFC with no hit -> next imem_addr=0; then rst for 1 cycle with 2 entries queued -> out_valid=0 and the first request goes to RESET_PC.
